// File: rtl/video_stream_pkg.sv
// Shared types and helpers for the frame-buffer-to-stream pixel source.
// Optional feature macro: VSS_TEST_PATTERN_EN (adds the colour-bar LUT).
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bit-replicate an in_w-bit channel, MSB first, to fill out_w bits.
  // Example: 4'h8 -> 10'b1000_1000_10 = 10'h222.
  function automatic logic [31:0] expand_ch(input logic [31:0] v,
                                            input int          in_w,
                                            input int          out_w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      if (j < out_w) r[out_w-1-j] = v[in_w-1-(j % in_w)];
    end
    return r;
  endfunction

  // Unsigned fixed-point gain with saturation to out_w bits.
  function automatic logic [31:0] sat_gain(input logic [31:0] e,
                                           input logic [31:0] g,
                                           input int          frac,
                                           input int          out_w);
    logic [63:0] prod;
    logic [63:0] max_v;
    prod  = ({32'd0, e} * {32'd0, g}) >> frac;
    max_v = (64'd1 << out_w) - 64'd1;
    return (prod > max_v) ? max_v[31:0] : prod[31:0];
  endfunction

`ifdef VSS_TEST_PATTERN_EN
  // Channel-enable mask per vertical bar; bit k lights channel k.
  localparam logic [2:0] BAR_COLOUR [8] = '{3'd0, 3'd1, 3'd2, 3'd3,
                                            3'd4, 3'd5, 3'd6, 3'd7};
`endif

endpackage

// File: rtl/video_stream_source_fifo.sv
// stream_fifo: shift-register FIFO whose head entry is a flop, so the
// output is fully registered. Carries pixel data plus sop/eop.
module stream_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] ent_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;
  logic             push_ok;
  int               wr_idx;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && (pop_ok || (cnt_q != CNT_W'(DEPTH)));
  assign wr_idx  = pop_ok ? int'(cnt_q) - 1 : int'(cnt_q);

  // Storage: shift toward the head on pop, write behind the last valid entry.
  // NOTE: the array is reset because its head drives src_data, which must read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_q[i] <= ent_q[i+1];
      end
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == wr_idx) ent_q[i] <= din_i;
        end
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = ent_q[0];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/video_stream_source.sv
// video_stream_source: reads a linear frame memory, expands each channel,
// applies per-channel saturating gain and streams pixels with sop/eop
// under ready/valid backpressure.
// Optional feature macro: VSS_TEST_PATTERN_EN (adds pattern_sel and colour bars).
module video_stream_source
  import video_stream_pkg::*;
#(
  parameter  int FRAME_W    = 320,
  parameter  int FRAME_H    = 240,
  parameter  int NUM_CH     = 3,
  parameter  int IN_CH_W    = 4,
  parameter  int OUT_CH_W   = 10,
  parameter  int GAIN_W     = 6,
  parameter  int GAIN_FRAC  = 4,
  parameter  int RD_LAT     = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(FRAME_W * FRAME_H)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [NUM_CH*IN_CH_W-1:0]    mem_rdata,
  input  logic [NUM_CH*GAIN_W-1:0]     gain,
`ifdef VSS_TEST_PATTERN_EN
  input  logic                         pattern_sel,
`endif
  output logic [NUM_CH*OUT_CH_W-1:0]   src_data,
  output logic                         src_valid,
  input  logic                         src_ready,
  output logic                         src_sop,
  output logic                         src_eop,
  output logic                         frame_done
);

  localparam int TOTAL = FRAME_W * FRAME_H;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = NUM_CH * OUT_CH_W;

  if ((RD_LAT < 1) || (FIFO_DEPTH < RD_LAT + 3)) begin : g_param_check
    $error("video_stream_source: need RD_LAT >= 1 and FIFO_DEPTH >= RD_LAT+3");
  end

  // Per-read side information that travels alongside the memory access.
  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [NUM_CH*GAIN_W-1:0] gain;
`ifdef VSS_TEST_PATTERN_EN
    logic                     pat;
    logic [2:0]               bar;
`endif
  } tag_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [NUM_CH*GAIN_W-1:0] gain_q;
  logic [CNT_W-1:0]         in_flight_q;
  logic [CNT_W-1:0]         fifo_count;
  logic                     issue;
  logic                     at_first;
  logic                     at_last;
  tag_t                     issue_tag;

  logic                     rd_vld_q [RD_LAT];
  tag_t                     rd_tag_q [RD_LAT];
  tag_t                     tag_out;

  logic [PIX_W-1:0]         px_d;
  logic [31:0]              exp_w;
  logic [31:0]              sat_w;
  logic                     st_vld_q;
  logic [PIX_W-1:0]         st_data_q;
  logic                     st_sop_q;
  logic                     st_eop_q;

  logic [PIX_W+1:0]         fifo_dout;
  logic                     frame_done_q;

`ifdef VSS_TEST_PATTERN_EN
  localparam int X_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  logic [X_W-1:0] x_q;
  logic           pat_q;
  logic [2:0]     colour_w;
`endif

  assign at_first = (addr_q == '0);
  assign at_last  = (addr_q == ADDR_W'(TOTAL - 1));
  // Reads stop once every FIFO slot is either occupied or already claimed.
  assign issue    = (state_q == RUN) &&
                    ((int'(fifo_count) + int'(in_flight_q)) < FIFO_DEPTH);

  // Side information for the read issued this cycle; gain is frozen at address 0.
  always_comb begin
    issue_tag      = '0;
    issue_tag.sop  = at_first;
    issue_tag.eop  = at_last;
    issue_tag.gain = at_first ? gain : gain_q;
`ifdef VSS_TEST_PATTERN_EN
    issue_tag.pat  = at_first ? pattern_sel : pat_q;
    issue_tag.bar  = 3'((int'(x_q) * 8) / FRAME_W);
`endif
  end

  // Control FSM: address generation, frame wrap and drain-to-idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gain_q  <= '0;
`ifdef VSS_TEST_PATTERN_EN
      x_q     <= '0;
      pat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= RUN;
        end
        RUN: begin
          if (issue) begin
            if (at_first) begin
              gain_q <= gain;
`ifdef VSS_TEST_PATTERN_EN
              pat_q  <= pattern_sel;
`endif
            end
            if (at_last) begin
              addr_q <= '0;
              if (!enable) state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
`ifdef VSS_TEST_PATTERN_EN
            x_q <= (x_q == X_W'(FRAME_W - 1)) ? '0 : x_q + X_W'(1);
`endif
          end
        end
        DRAIN: begin
          if ((fifo_count == '0) && (in_flight_q == '0)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag delay line matching the memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_tag_q[i] <= '0;
      end
    end else begin
      rd_vld_q[0] <= issue;
      rd_tag_q[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
    end
  end

  assign tag_out = rd_tag_q[RD_LAT-1];

  // Channel expansion (or colour bar) followed by saturating gain.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    px_d  = '0;
    exp_w = '0;
    sat_w = '0;
`ifdef VSS_TEST_PATTERN_EN
    colour_w = BAR_COLOUR[tag_out.bar];
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_w = expand_ch(32'(mem_rdata[ch*IN_CH_W +: IN_CH_W]), IN_CH_W, OUT_CH_W);
`ifdef VSS_TEST_PATTERN_EN
      if (tag_out.pat) begin
        exp_w = ((ch < 3) && colour_w[ch]) ? ((32'd1 << OUT_CH_W) - 32'd1) : 32'd0;
      end
`endif
      sat_w = sat_gain(exp_w, 32'(tag_out.gain[ch*GAIN_W +: GAIN_W]), GAIN_FRAC, OUT_CH_W);
      px_d[ch*OUT_CH_W +: OUT_CH_W] = sat_w[OUT_CH_W-1:0];
    end
  end

  // Pixel register between the memory return and the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_vld_q  <= 1'b0;
      st_data_q <= '0;
      st_sop_q  <= 1'b0;
      st_eop_q  <= 1'b0;
    end else begin
      st_vld_q  <= rd_vld_q[RD_LAT-1];
      st_data_q <= px_d;
      st_sop_q  <= tag_out.sop;
      st_eop_q  <= tag_out.eop;
    end
  end

  // Reads issued but not yet written into the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_flight_q <= '0;
    end else begin
      case ({issue, st_vld_q})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W + 2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (st_vld_q),
    .din_i   ({st_sop_q, st_eop_q, st_data_q}),
    .pop_i   (src_valid && src_ready),
    .dout_o  (fifo_dout),
    .valid_o (src_valid),
    .count_o (fifo_count)
  );

  // One-cycle pulse following acceptance of the end-of-frame beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_done_q <= 1'b0;
    else          frame_done_q <= src_valid && src_ready && src_eop;
  end

  assign mem_addr   = addr_q;
  assign src_data   = fifo_dout[PIX_W-1:0];
  assign src_eop    = fifo_dout[PIX_W];
  assign src_sop    = fifo_dout[PIX_W+1];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_stream_source.sv
// Scoreboard bench for video_stream_source on a 4x2 frame.
// Expected beats are queued when a frame is launched; a monitor pops and
// compares every accepted beat and checks hold-stability while stalled.
module tb_video_stream_source;

  localparam int FW   = 4;
  localparam int FH   = 2;
  localparam int NCH  = 3;
  localparam int IW   = 4;
  localparam int OW   = 10;
  localparam int GW   = 6;
  localparam int GF   = 4;
  localparam int RL   = 1;
  localparam int FD   = 4;
  localparam int NPIX = FW * FH;
  localparam int AW   = $clog2(NPIX);
  localparam int DW   = NCH * OW;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [AW-1:0]     mem_addr;
  logic [NCH*IW-1:0] mem_rdata;
  logic [NCH*GW-1:0] gain;
  logic [DW-1:0]     src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic              frame_done;
`ifdef VSS_TEST_PATTERN_EN
  logic              pattern_sel;
`endif

  beat_t exp_q[$];
  int    n_vec;
  int    n_err;
  int    fd_cnt;
  int    fd_exp;
  int    mem_mode;
  bit    lfsr_on;
  logic [7:0] lfsr;

  // Hand-computed 4-bit -> 10-bit replication results.
  logic [9:0] exp_lut [16] = '{10'h000, 10'h044, 10'h088, 10'h0CC,
                               10'h111, 10'h155, 10'h199, 10'h1DD,
                               10'h222, 10'h266, 10'h2AA, 10'h2EE,
                               10'h333, 10'h377, 10'h3BB, 10'h3FF};

  video_stream_source #(
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .NUM_CH     (NCH),
    .IN_CH_W    (IW),
    .OUT_CH_W   (OW),
    .GAIN_W     (GW),
    .GAIN_FRAC  (GF),
    .RD_LAT     (RL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .gain       (gain),
`ifdef VSS_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mem_word(input int a, input int mode);
    case (mode)
      0:       return 12'(a);
      1:       return 12'hFFF;
      default: return {4'(a + 8), 4'(15 - a), 4'(2 * a + 1)};
    endcase
  endfunction

  // Single-cycle-latency frame memory model.
  always @(posedge clk) mem_rdata <= mem_word(int'(mem_addr), mem_mode);

  function automatic logic [9:0] apply_gain(input logic [9:0] e, input logic [5:0] g);
    int p;
    p = (int'(e) * int'(g)) >> GF;
    return (p > 1023) ? 10'h3FF : 10'(p);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int mode, input logic [NCH*GW-1:0] g, input bit pat);
    beat_t       b;
    logic [11:0] w;
    logic [9:0]  e;
    int          bar;
    for (int a = 0; a < NPIX; a++) begin
      w   = mem_word(a, mode);
      bar = ((a % FW) * 8) / FW;
      b.data = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        e = exp_lut[w[ch*IW +: IW]];
        if (pat) e = bar[ch] ? 10'h3FF : 10'h000;
        b.data[ch*OW +: OW] = apply_gain(e, g[ch*GW +: GW]);
      end
      b.sop = (a == 0);
      b.eop = (a == NPIX - 1);
      exp_q.push_back(b);
    end
    fd_exp++;
  endtask

  task automatic start_one_frame();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || src_valid) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("drain: beats left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("frame_done count", fd_cnt, fd_exp);
  endtask

  task automatic wait_addr(input int a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((int'(mem_addr) != a) && (n < 60));
    check("reach address", mem_addr, a);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   edges;
    bit   stall_q;
    logic [DW+2:0] held;
    beat_t b;

    n_vec = 0; n_err = 0; fd_cnt = 0; fd_exp = 0;
    reset_n = 1'b0; enable = 1'b0; src_ready = 1'b1; mem_mode = 0;
    gain = {6'd16, 6'd16, 6'd16}; lfsr_on = 1'b0; lfsr = 8'hA5;
    stall_q = 1'b0; held = '0;
`ifdef VSS_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif

    fork
      // Monitor: scoreboard pop/compare plus stability while stalled.
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          stall_q = 1'b0;
        end else begin
          if (frame_done) fd_cnt++;
          if (stall_q) check("hold while stalled", {src_valid, src_sop, src_eop, src_data}, held);
          if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL spurious beat: data %0h with empty scoreboard", src_data);
            end else begin
              b = exp_q.pop_front();
              check("beat data", src_data, b.data);
              check("beat sop", src_sop, b.sop);
              check("beat eop", src_eop, b.eop);
            end
          end
          stall_q = src_valid && !src_ready;
          held    = {src_valid, src_sop, src_eop, src_data};
        end
      end
      // Pseudo-random backpressure.
      forever begin
        @(posedge clk);
        #1;
        if (lfsr_on) begin
          lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          src_ready = lfsr[0];
        end
      end
    join_none

    // Reset values.
    #22;
    check("reset src_valid", src_valid, 0);
    check("reset sop/eop", {src_sop, src_eop}, 0);
    check("reset src_data", src_data, 0);
    check("reset frame_done", frame_done, 0);
    check("reset mem_addr", mem_addr, 0);
    reset_n = 1'b1;

    // 1: identity gain, mem = addr, latency to first valid.
    push_frame(0, gain, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) enable = 1'b0;
    end while (!src_valid && (edges < 20));
    check("first valid edge", edges, RL + 3);
    wait_drain(200);
    check("idle address", mem_addr, 0);

    // 2: random backpressure, non-trivial data and gains.
    gain = {6'd12, 6'd16, 6'd20};
    mem_mode = 2;
    push_frame(2, gain, 1'b0);
    lfsr_on = 1'b1;
    start_one_frame();
    wait_drain(400);
    @(posedge clk); #1 lfsr_on = 1'b0; src_ready = 1'b1;

    // 3: long stall, reads must stop at FIFO_DEPTH.
    gain = {6'd16, 6'd16, 6'd16};
    mem_mode = 0;
    push_frame(0, gain, 1'b0);
    @(posedge clk); #1 src_ready = 1'b0;
    start_one_frame();
    repeat (50) @(negedge clk);
    check("reads issued under stall", mem_addr, FD);
    check("valid held under stall", src_valid, 1);
    @(posedge clk); #1 src_ready = 1'b1;
    wait_drain(200);

    // 4: saturation and zero gain.
    mem_mode = 1;
    gain = {6'd32, 6'd32, 6'd32};
    push_frame(1, gain, 1'b0);
    start_one_frame();
    wait_drain(200);
    gain = '0;
    push_frame(1, gain, 1'b0);
    start_one_frame();
    wait_drain(200);

    // 5: gain change mid-frame, then enable dropped mid-frame.
    mem_mode = 2;
    gain = {6'd8, 6'd24, 6'd16};
    push_frame(2, gain, 1'b0);
    push_frame(2, {6'd40, 6'd4, 6'd63}, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    wait_addr(3);
    gain = {6'd40, 6'd4, 6'd63};
    wait_addr(0);
    wait_addr(3);
    enable = 1'b0;
    wait_drain(300);
    check("idle after drop", {src_valid, mem_addr}, 0);

    // 6: asynchronous reset mid-frame, then a clean restart.
    mem_mode = 0;
    gain = {6'd16, 6'd16, 6'd16};
    push_frame(0, gain, 1'b0);
    start_one_frame();
    wait_addr(5);
    #2 reset_n = 1'b0;
    #1;
    check("async reset valid", src_valid, 0);
    check("async reset data", {src_sop, src_eop, src_data}, 0);
    check("async reset addr", mem_addr, 0);
    exp_q.delete();
    fd_exp--;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    push_frame(0, gain, 1'b0);
    start_one_frame();
    wait_drain(200);

`ifdef VSS_TEST_PATTERN_EN
    // Colour bars replace memory data; gain still applies.
    pattern_sel = 1'b1;
    gain = {6'd16, 6'd16, 6'd16};
    push_frame(0, gain, 1'b1);
    start_one_frame();
    @(posedge clk); #1 pattern_sel = 1'b0;
    wait_drain(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
